// File: rtl/button_conditioner.sv
// button_conditioner: per-channel two-flop synchroniser followed by a
// two-state debounce FSM with a qualification counter. Each channel drives
// a clean level on clean_out and a busy flag while a change is qualifying.
// Optional press/release strobes are built when the macro
// BUTTON_CONDITIONER_EVENTS_EN is defined. Otherwise both strobe ports are
// tied to 0.
module button_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } state_t;

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;

  // Synchroniser next-state: shift the raw pins one stage per clock.
  always_comb begin
    s1_d = raw_in;
    s2_d = s1_q;
  end

  // Synchroniser registers. They reset to the idle level so that a reset
  // does not look like a press.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= IDLE_VEC;
      s2_q <= IDLE_VEC;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;

    // Debounce FSM: start qualifying on disagreement, drop it on a glitch,
    // and accept the new level once the counter reaches its last value.
    // NOTE: every output of this block gets a default first. A path that
    // left one unassigned would infer a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      case (state_q)
        ST_STABLE: begin
          if (s2_q[i] != clean_q) begin
            state_d = ST_QUAL;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        ST_QUAL: begin
          if (s2_q[i] == clean_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            clean_d = s2_q[i];
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Per-channel FSM state, counter and clean level.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        clean_q <= IDLE_LEVEL;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
      end
    end

    assign clean_out[i] = clean_q;
    assign busy[i]      = (state_q == ST_QUAL);

`ifdef BUTTON_CONDITIONER_EVENTS_EN
    logic press_q, press_d;
    logic release_q, release_d;

    // Strobe next-state: a toggle of the clean level, split by direction.
    always_comb begin
      press_d   = (clean_d != clean_q) && (clean_d != IDLE_LEVEL);
      release_d = (clean_d != clean_q) && (clean_d == IDLE_LEVEL);
    end

    // Strobe registers. They assert on the edge where clean_out toggles.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
`else
    assign press_pulse[i]   = 1'b0;
    assign release_pulse[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with WIDTH=4, DEBOUNCE_CYCLES=8 and
// IDLE_LEVEL=1. Edge k is the k-th rising clock edge after raw_in changes
// (edge 0 samples the new value). Outputs are sampled 1 ns after each edge.
module tb_button_conditioner;

  localparam int WIDTH = 4;
  localparam int DEB   = 8;

`ifdef BUTTON_CONDITIONER_EVENTS_EN
  localparam bit EV_ON = 1'b1;
`else
  localparam bit EV_ON = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean_out;
  logic [WIDTH-1:0] busy;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;

  int n_total = 0;
  int n_bad   = 0;

  button_conditioner #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .IDLE_LEVEL     (1'b1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .raw_in       (raw_in),
    .clean_out    (clean_out),
    .busy         (busy),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a clean step to new_raw, starting from a settled state where
  // clean_out == old_clean. Check timing, busy and strobes through edge 10.
  task automatic step(input string tag, input logic [3:0] old_clean, input logic [3:0] new_raw);
    logic [3:0] chg;
    logic [3:0] exp_press;
    logic [3:0] exp_rel;
    chg       = old_clean ^ new_raw;
    exp_press = EV_ON ? (chg & ~new_raw) : 4'h0;
    exp_rel   = EV_ON ? (chg & new_raw) : 4'h0;
    raw_in = new_raw;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 1) check({tag, "_busy_e1"}, busy, 4'h0);
      if (k == 2) check({tag, "_busy_e2"}, busy, chg);
      if (k == 8) begin
        check({tag, "_clean_e8"}, clean_out, old_clean);
        check({tag, "_busy_e8"}, busy, chg);
        check({tag, "_press_e8"}, press_pulse, 4'h0);
      end
      if (k == 9) begin
        check({tag, "_clean_e9"}, clean_out, new_raw);
        check({tag, "_busy_e9"}, busy, 4'h0);
        check({tag, "_press_e9"}, press_pulse, exp_press);
        check({tag, "_rel_e9"}, release_pulse, exp_rel);
      end
      if (k == 10) begin
        check({tag, "_press_e10"}, press_pulse, 4'h0);
        check({tag, "_rel_e10"}, release_pulse, 4'h0);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    raw_in  = 4'h0;

    // 1. Reset with the pins held active, then release.
    repeat (3) tick();
    check("rst_clean", clean_out, 4'hf);
    check("rst_busy", busy, 4'h0);
    check("rst_press", press_pulse, 4'h0);
    check("rst_rel", release_pulse, 4'h0);
    reset_n = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      tick();
      if (k <= 8) check($sformatf("rel_clean_e%0d", k), clean_out, 4'hf);
      else begin
        check("rel_clean_e9", clean_out, 4'h0);
        check("rel_press_e9", press_pulse, EV_ON ? 4'hf : 4'h0);
      end
    end
    tick();
    step("s1_up", 4'h0, 4'hf);

    // 2. Clean press and release on channel 0.
    step("s2_dn", 4'hf, 4'he);
    step("s2_up", 4'he, 4'hf);

    // 3. Bouncing channel 1: low 7, high 1, low 7, then high.
    raw_in = 4'hd;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("s3_clean_e%0d", k), {31'd0, clean_out[1]}, 32'd1);
      check($sformatf("s3_busy_e%0d", k), {31'd0, busy[1]},
            ((k >= 2 && k <= 8) || (k >= 10 && k <= 16)) ? 32'd1 : 32'd0);
      check($sformatf("s3_press_e%0d", k), press_pulse, 4'h0);
      raw_in = ((k + 1 <= 6) || (k + 1 >= 8 && k + 1 <= 14)) ? 4'hd : 4'hf;
    end

    // 4. All four channels change together.
    step("s4_dn", 4'hf, 4'h0);
    step("s4_up", 4'h0, 4'hf);

    // 5. Reset in the middle of a press on channel 2.
    raw_in = 4'hb;
    for (int k = 0; k <= 6; k++) tick();
    check("s5_busy_cnt5", busy, 4'h4);
    reset_n = 1'b0;
    #1;
    check("s5_rst_clean", clean_out, 4'hf);
    check("s5_rst_busy", busy, 4'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      tick();
      if (k == 8) check("s5_clean_e8", clean_out, 4'hf);
      if (k == 9) begin
        check("s5_clean_e9", clean_out, 4'hb);
        check("s5_press_e9", press_pulse, EV_ON ? 4'h4 : 4'h0);
      end
    end
    tick();
    step("s5_up", 4'hb, 4'hf);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
